corr_seq_ctrl: RTL

Sequencer for the 32-lag RAM-based MAC bank (8-bit in, 32-bit accumulators) of the autocorrelator. It clears the bank, then accepts n_int samples. For each sample it launches one 32-cycle MAC sweep, feeding A = newest sample and B = sample delayed by lag k. It then reads the 32 accumulators out through a 4-entry output FIFO with valid/ready backpressure. The bank gets its clock and reset from the same clk/rst_n.

---
 rtl/corr_seq_ctrl_pkg.sv | 28 ++
 rtl/corr_seq_ctrl_out_fifo.sv | 60 ++++++
 rtl/corr_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/corr_seq_ctrl_pkg.sv
// Shared constants and state encoding for the autocorrelator sequencer.
//   LAGS     : number of lags in the MAC bank (fixed by the bank)
//   SW       : sample width
//   AW       : lag / address width
//   DW       : accumulator width
//   NW       : integration-count width
//   FD       : output FIFO depth
//   BANK_OCC : cycles from a mac_sin/mac_clr pulse until the bank is idle again
package corr_pkg;

  localparam int LAGS     = 32;
  localparam int SW       = 8;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NW       = 16;
  localparam int FD       = 4;
  localparam int BANK_OCC = 33;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WAIT_S,
    SWEEP,
    RD,
    DRAIN
  } state_t;

endpackage

// File: rtl/corr_seq_ctrl_out_fifo.sv
// Small synchronous FIFO for {lag, accumulator} readout entries.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared too,
//                so the head reads as zero after reset)
//   push       : write push_data this cycle (caller guarantees not full)
//   pop        : drop the head entry this cycle (caller guarantees not empty)
//   pop_data   : current head entry
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
module corr_out_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/corr_seq_ctrl.sv
// Sequencer for the 32-lag RAM-based MAC bank of the autocorrelator.
// Clears the bank, feeds n_int samples (one 32-cycle sweep each, A = newest
// sample, B = sample delayed by lag k), then reads the 32 accumulators out
// through a small FIFO with valid/ready handshaking.
//   start, n_int                    : begin an integration of n_int samples
//   s_valid, s_data, s_ready        : sample input stream
//   mac_clr, mac_sin, mac_A, mac_B  : registered bank sweep controls / operands
//   mac_read, mac_rAddr, mac_rData  : bank readout (read latency 2)
//   out_valid/data/lag/last, ready  : result stream, lag 0..31 in order
//   busy, done                      : status; done pulses after the lag-31 handshake
module corr_seq_ctrl
  import corr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n_int,
  input  logic          s_valid,
  input  logic [SW-1:0] s_data,
  output logic          s_ready,
  output logic          mac_clr,
  output logic          mac_sin,
  output logic [SW-1:0] mac_A,
  output logic [SW-1:0] mac_B,
  output logic          mac_read,
  output logic [AW-1:0] mac_rAddr,
  input  logic [DW-1:0] mac_rData,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_lag,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int TW   = 6;
  localparam int ILW  = AW + 1;
  localparam int CW   = $clog2(FD + 1);
  localparam int SUMW = CW + 1;

  state_t          state, state_d;
  logic [NW-1:0]   n_int_q, n_int_d;
  logic [NW-1:0]   cnt, cnt_d;
  logic [TW-1:0]   timer, timer_d;
  logic [ILW-1:0]  iss_lag, iss_lag_d;
  logic            mac_clr_d, mac_sin_d, mac_read_d, done_d;
  logic [SW-1:0]   mac_A_d, mac_B_d;
  logic [AW-1:0]   mac_rAddr_d;
  logic            hist_clr, hist_shift;
  logic [SW-1:0]   hist [LAGS];

  logic            vld_p0, vld_p0_d, vld_p1, vld_p2;
  logic [AW-1:0]   lag_p1, lag_p2;

  logic            fifo_empty, fifo_pop;
  logic [CW-1:0]   fifo_cnt;
  logic [AW+DW-1:0] fifo_head;
  logic [SUMW-1:0] credit_sum;
  logic            credit_ok;

  // Occupancy plus every read still in the 2-deep pipe; pops are ignored,
  // so a new issue can never find the FIFO full when it lands.
  assign credit_sum = SUMW'(fifo_cnt) + SUMW'(vld_p0) + SUMW'(vld_p1) + SUMW'(vld_p2);
  assign credit_ok  = (credit_sum < SUMW'(FD));

  assign s_ready   = (state == WAIT_S);
  assign busy      = (state != IDLE);
  assign out_valid = !fifo_empty;
  assign out_lag   = fifo_head[AW+DW-1:DW];
  assign out_data  = fifo_head[DW-1:0];
  assign out_last  = out_valid && (out_lag == AW'(LAGS - 1));
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    state_d     = state;
    n_int_d     = n_int_q;
    cnt_d       = cnt;
    timer_d     = timer;
    iss_lag_d   = iss_lag;
    mac_clr_d   = 1'b0;
    mac_sin_d   = 1'b0;
    mac_A_d     = mac_A;
    mac_B_d     = mac_B;
    mac_read_d  = mac_read;
    mac_rAddr_d = mac_rAddr;
    vld_p0_d    = 1'b0;
    done_d      = 1'b0;
    hist_clr    = 1'b0;
    hist_shift  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          n_int_d   = n_int;
          cnt_d     = '0;
          timer_d   = '0;
          hist_clr  = 1'b1;
          mac_clr_d = 1'b1;
          mac_A_d   = '0;
          mac_B_d   = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        timer_d = timer + TW'(1);
        if (timer == TW'(BANK_OCC - 1)) begin
          timer_d = '0;
          if (n_int_q == '0) begin
            mac_read_d = 1'b1;
            iss_lag_d  = '0;
            state_d    = RD;
          end else begin
            state_d = WAIT_S;
          end
        end
      end
      WAIT_S: begin
        if (s_valid) begin
          hist_shift = 1'b1;
          mac_A_d    = s_data;
          mac_sin_d  = 1'b1;
          cnt_d      = cnt + NW'(1);
          timer_d    = '0;
          state_d    = SWEEP;
        end
      end
      SWEEP: begin
        // timer==0 is the mac_sin cycle; B for lag k is registered one
        // cycle ahead so it is on the port during bank sweep cycle k.
        if (timer < TW'(LAGS)) mac_B_d = hist[timer[AW-1:0]];
        else                   mac_B_d = '0;
        timer_d = timer + TW'(1);
        if (timer == TW'(BANK_OCC - 1)) begin
          timer_d = '0;
          if (cnt == n_int_q) begin
            mac_read_d = 1'b1;
            iss_lag_d  = '0;
            state_d    = RD;
          end else begin
            state_d = WAIT_S;
          end
        end
      end
      RD: begin
        if (iss_lag < ILW'(LAGS) && credit_ok) begin
          vld_p0_d    = 1'b1;
          mac_rAddr_d = iss_lag[AW-1:0];
          iss_lag_d   = iss_lag + ILW'(1);
        end
        if (vld_p2 && lag_p2 == AW'(LAGS - 1)) begin
          mac_read_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && out_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_int_q   <= '0;
      cnt       <= '0;
      timer     <= '0;
      iss_lag   <= '0;
      mac_clr   <= 1'b0;
      mac_sin   <= 1'b0;
      mac_A     <= '0;
      mac_B     <= '0;
      mac_read  <= 1'b0;
      mac_rAddr <= '0;
      done      <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      state     <= state_d;
      n_int_q   <= n_int_d;
      cnt       <= cnt_d;
      timer     <= timer_d;
      iss_lag   <= iss_lag_d;
      mac_clr   <= mac_clr_d;
      mac_sin   <= mac_sin_d;
      mac_A     <= mac_A_d;
      mac_B     <= mac_B_d;
      mac_read  <= mac_read_d;
      mac_rAddr <= mac_rAddr_d;
      done      <= done_d;
      // p0 -> p1 -> p2: read issued, in bank, data on mac_rData
      vld_p0    <= vld_p0_d;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
    end
  end

  // p0 -> p1 -> p2 lag tags, qualified by vld_pN
  always_ff @(posedge clk) begin
    lag_p1 <= mac_rAddr;
    lag_p2 <= lag_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAGS; i++) hist[i] <= '0;
    end else if (hist_clr) begin
      for (int i = 0; i < LAGS; i++) hist[i] <= '0;
    end else if (hist_shift) begin
      hist[0] <= s_data;
      for (int i = 1; i < LAGS; i++) hist[i] <= hist[i-1];
    end
  end

  corr_out_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (FD)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p2),
    .push_data ({lag_p2, mac_rData}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule
